// File: rtl/nd_display_scanner.sv
// nd_display_scanner: qualifies the CPU's active-low ND strobe, captures the
// L nibble into a DIGITS-deep shift buffer and multiplexes the buffered
// digits onto a common-cathode 7-segment display.
module nd_display_scanner #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1024,
  parameter int MIN_LOW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [3:0]        nl_n,
  input  logic              nd,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_sel_n,
  output logic              cap_valid,
  output logic [3:0]        cap_data
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int LW = $clog2(MIN_LOW + 1);

  // Two-flop synchronisers; these run even while ena is low.
  logic              nd_meta_q, nd_s_q;
  logic [3:0]        nl_meta_q, nl_s_q;

  logic [LW-1:0]     low_cnt_q, low_cnt_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [3:0]        dbuf_q [DIGITS];
  logic [3:0]        dbuf_d [DIGITS];
  logic [DIGITS-1:0] valid_q, valid_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dig_sel_n_q, dig_sel_n_d;
  logic              cap_valid_q, cap_valid_d;
  logic [3:0]        cap_data_q, cap_data_d;
  logic              accept;

  // Hex digit to {g,f,e,d,c,b,a} segment pattern.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Synchronise ND and L into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      nd_meta_q <= 1'b1;
      nd_s_q    <= 1'b1;
      nl_meta_q <= 4'hF;
      nl_s_q    <= 4'hF;
    end else begin
      nd_meta_q <= nd;
      nd_s_q    <= nd_meta_q;
      nl_meta_q <= nl_n;
      nl_s_q    <= nl_meta_q;
    end
  end

  // Strobe qualification, capture shift, scan sequencing and output decode.
  always_comb begin
    // A rising ND is accepted only after a long-enough low; the counter
    // clears on high even with ena low, so a rise seen while disabled is lost.
    accept    = ena && nd_s_q && (low_cnt_q >= LW'(MIN_LOW));
    low_cnt_d = low_cnt_q;
    if (nd_s_q) begin
      low_cnt_d = '0;
    end else if (ena && (low_cnt_q < LW'(MIN_LOW))) begin
      low_cnt_d = low_cnt_q + 1'b1;
    end

    presc_d = presc_q;
    idx_d   = idx_q;
    if (ena) begin
      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_d = '0;
        idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    for (int k = 0; k < DIGITS; k++) begin
      dbuf_d[k] = dbuf_q[k];
    end
    valid_d     = valid_q;
    cap_data_d  = cap_data_q;
    cap_valid_d = accept;
    if (accept) begin
      // Newest digit enters at slot 0; the oldest falls off the end.
      for (int k = DIGITS - 1; k > 0; k--) begin
        dbuf_d[k] = dbuf_q[k - 1];
      end
      dbuf_d[0]  = ~nl_s_q;
      valid_d    = {valid_q[DIGITS-2:0], 1'b1};
      cap_data_d = ~nl_s_q;
    end

    // Outputs are decoded from next state so a capture coinciding with a
    // digit advance shows the shifted buffer at the new index immediately.
    seg_d       = seg_q;
    dig_sel_n_d = dig_sel_n_q;
    if (ena) begin
      seg_d       = valid_d[idx_d] ? hex7(dbuf_d[idx_d]) : 7'h00;
      dig_sel_n_d = (presc_d == PW'(SCAN_DIV - 1)) ? '1
                                                   : ~(DIGITS'(1) << idx_d);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_cnt_q   <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      for (int k = 0; k < DIGITS; k++) begin
        dbuf_q[k] <= 4'h0;
      end
      valid_q     <= '0;
      seg_q       <= 7'h00;
      dig_sel_n_q <= '1;
      cap_valid_q <= 1'b0;
      cap_data_q  <= 4'h0;
    end else begin
      low_cnt_q   <= low_cnt_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      for (int k = 0; k < DIGITS; k++) begin
        dbuf_q[k] <= dbuf_d[k];
      end
      valid_q     <= valid_d;
      seg_q       <= seg_d;
      dig_sel_n_q <= dig_sel_n_d;
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
    end
  end

  assign seg       = seg_q;
  assign dig_sel_n = dig_sel_n_q;
  assign cap_valid = cap_valid_q;
  assign cap_data  = cap_data_q;

endmodule

// File: tb/tb_nd_display_scanner.sv
// Testbench for nd_display_scanner: stimulus pushes expected captures into a
// scoreboard; a negedge monitor pops them on cap_valid and checks the
// multiplexed display against a digit-list model of the scanner.
module tb_nd_display_scanner;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 8;
  localparam int MIN_LOW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic [3:0]        nl_n;
  logic              nd;
  logic [6:0]        seg;
  logic [DIGITS-1:0] dig_sel_n;
  logic              cap_valid;
  logic [3:0]        cap_data;

  always #5 clk = ~clk;

  nd_display_scanner #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .MIN_LOW (MIN_LOW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .nl_n     (nl_n),
    .nd       (nd),
    .seg      (seg),
    .dig_sel_n(dig_sel_n),
    .cap_valid(cap_valid),
    .cap_data (cap_data)
  );

  typedef struct {
    logic [3:0] val;
    int         at;
  } cap_t;

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;   // rising edges seen
  int         k_en        = 0;   // enabled edges since reset
  bit         out_rst     = 1'b1;
  cap_t       exp_q[$];
  logic [3:0] shown_q[$];        // newest captured digit first
  logic [3:0] last_cap    = 4'h0;
  logic [6:0] HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int         LOWS [5] = '{1, 2, 2, 3, 4};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Abstract time base: reset clears everything, each enabled edge advances one tick.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      k_en     = 0;
      out_rst  = 1'b1;
      exp_q.delete();
      shown_q.delete();
      last_cap = 4'h0;
    end else if (ena) begin
      k_en++;
      out_rst = 1'b0;
    end
  end

  // Monitor: retire captures from the scoreboard, then check the display.
  always @(negedge clk) begin : monitor
    cap_t              e;
    int                presc;
    int                idx;
    logic [6:0]        e_seg;
    logic [DIGITS-1:0] e_dig;
    if (cyc > 0) begin
      if (cap_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_cap_valid", 32'(cap_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("cap_cycle", 32'(cyc), 32'(e.at));
          check("cap_data", 32'(cap_data), 32'(e.val));
          shown_q.push_front(e.val);
          if (shown_q.size() > DIGITS) void'(shown_q.pop_back());
          last_cap = e.val;
          $display("capture value=%h at cycle %0d", e.val, cyc);
        end
      end else begin
        check("cap_data_hold", 32'(cap_data), 32'(last_cap));
      end
      if (out_rst) begin
        e_seg = 7'h00;
        e_dig = '1;
      end else begin
        presc = k_en % SCAN_DIV;
        idx   = (k_en / SCAN_DIV) % DIGITS;
        e_dig = (presc == SCAN_DIV - 1) ? '1 : ~(DIGITS'(1) << idx);
        e_seg = (idx < shown_q.size()) ? HEX7[shown_q[idx]] : 7'h00;
      end
      check("seg", 32'(seg), 32'(e_seg));
      check("dig_sel_n", 32'(dig_sel_n), 32'(e_dig));
    end
  end

  // One ND low pulse of lowlen cycles; a pulse of at least MIN_LOW is expected
  // to surface on cap_valid three clocks after the rise.
  task automatic strobe(input logic [3:0] v, input int lowlen, input int gap);
    nl_n = ~v;
    nd   = 1'b0;
    ena  = 1'b1;
    repeat (lowlen) @(negedge clk);
    nd = 1'b1;
    if (lowlen >= MIN_LOW) exp_q.push_back('{v, cyc + 3});
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    ena  = 1'b1;
    nd   = 1'b1;
    nl_n = 4'hF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single capture of 5, then watch a full scan.
    strobe(4'h5, 2, 12);
    repeat (40) @(negedge clk);

    // Five captures overflow the four-digit buffer.
    for (int i = 1; i <= 5; i++) strobe(4'(i), 2, 6);
    repeat (40) @(negedge clk);

    // Glitch is rejected; RNP-style all-high L captures zero.
    strobe(4'h9, 1, 6);
    strobe(4'h0, 2, 6);
    repeat (32) @(negedge clk);

    // Rise timed so the accept cycle coincides with the prescaler wrap.
    nl_n = ~4'h7;
    nd   = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (k_en % SCAN_DIV == 5) break;
      @(negedge clk);
    end
    nd = 1'b1;
    exp_q.push_back('{4'h7, cyc + 3});
    repeat (20) @(negedge clk);

    // ena low across the rise: strobe lost, outputs frozen.
    nl_n = ~4'h9;
    nd   = 1'b0;
    repeat (3) @(negedge clk);
    nd  = 1'b1;
    ena = 1'b0;
    repeat (6) @(negedge clk);
    ena = 1'b1;
    repeat (10) @(negedge clk);

    // Reset in the middle of a low; the later rise is not accepted.
    nl_n = ~4'h3;
    nd   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nd = 1'b1;
    repeat (20) @(negedge clk);

    // Randomised strobes with disabled stretches between them.
    for (int i = 0; i < 40; i++) begin
      strobe(4'($urandom_range(0, 15)), LOWS[$urandom_range(0, 4)], 4);
      repeat ($urandom_range(0, 14)) begin
        ena = ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
      ena = 1'b1;
    end

    repeat (10) @(negedge clk);
    check("pending_captures", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
